param_serializer: RTL

Parametrised parallel-to-serial shifter, the next generation of the UART TX serializer. Captures a DATA_W-bit word on a load strobe and shifts it out one bit per ser_en tick, LSB-first or MSB-first. Drives busy and ser_done status for the TX control FSM, with an optional parity bit appended after the data. Sits between the TX FSM/baud-tick generator and the TX output mux.

---
 rtl/param_serializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter for the UART TX path.
// Captures a DATA_W-bit word on load (only while idle) and shifts it out one
// bit per ser_en tick, LSB-first or MSB-first. The first bit reaches the line
// on the same edge that captures the word.
//
// Optional feature: define SERIALIZER_PARITY_EN to append a parity bit
// (even, or odd when PAR_ODD=1) after the last data bit.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_in  in   [DATA_W] parallel word to serialize
//   load     in   capture strobe, ignored while busy
//   ser_en   in   shift tick; each asserted cycle ends one bit period
//   ser_data out  registered serial line, IDLE_LVL while not busy
//   ser_done out  one-cycle pulse when the frame completes
//   busy     out  high while a frame is being serialized
module param_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          IDLE_LVL  = 1'b0,
  parameter bit          PAR_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              ser_en,
  output logic              ser_data,
  output logic              ser_done,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ser_data_q, ser_data_d;
  logic                ser_done_q, ser_done_d;
  logic                busy_q, busy_d;
  logic                last_bit_c;
`ifdef SERIALIZER_PARITY_EN
  logic                par_q, par_d;
`else
  // Parity sense only matters when the parity bit exists.
  logic                unused_par_odd;
  assign unused_par_odd = PAR_ODD;
`endif

  assign last_bit_c = (cnt_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      ser_data_q <= IDLE_LVL;
      ser_done_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_done_q <= ser_done_d;
      busy_q     <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ser_en && last_bit_c) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (ser_en) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs. The shift register keeps the bit on the
  // line at the end it shifts away from, so the next bit is always one in.
  always_comb begin
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    ser_data_d = ser_data_q;
    ser_done_d = 1'b0;
    busy_d     = busy_q;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ser_data_d = IDLE_LVL;
        if (load) begin
          sreg_d     = data_in;
          cnt_d      = '0;
          busy_d     = 1'b1;
          ser_data_d = MSB_FIRST ? data_in[DATA_W-1] : data_in[0];
`ifdef SERIALIZER_PARITY_EN
          par_d      = (^data_in) ^ PAR_ODD;
`endif
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          if (!last_bit_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (MSB_FIRST) begin
              sreg_d     = sreg_q << 1;
              ser_data_d = sreg_q[DATA_W-2];
            end else begin
              sreg_d     = sreg_q >> 1;
              ser_data_d = sreg_q[1];
            end
          end else begin
`ifdef SERIALIZER_PARITY_EN
            ser_data_d = par_q;
`else
            ser_done_d = 1'b1;
            busy_d     = 1'b0;
            ser_data_d = IDLE_LVL;
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (ser_en) begin
          ser_done_d = 1'b1;
          busy_d     = 1'b0;
          ser_data_d = IDLE_LVL;
        end
      end
`endif
      default: begin
        busy_d     = 1'b0;
        ser_data_d = IDLE_LVL;
      end
    endcase
  end

  assign ser_data = ser_data_q;
  assign ser_done = ser_done_q;
  assign busy     = busy_q;

endmodule
